// File: rtl/rs_encoder_pkg.sv
// Shared constants, state encoding and GF(16) helper for the RS(15,11) encoder.
// Field is GF(16) with primitive polynomial x^4+x+1.
package rs_encoder_pkg;

    localparam int N     = 15;
    localparam int K     = 11;
    localparam int SYM_W = 4;

    // g(x) = x^4 + G3 x^3 + G2 x^2 + G1 x + G0, roots alpha^1..alpha^4
    localparam logic [SYM_W-1:0] G3 = 4'd13;
    localparam logic [SYM_W-1:0] G2 = 4'd12;
    localparam logic [SYM_W-1:0] G1 = 4'd8;
    localparam logic [SYM_W-1:0] G0 = 4'd7;

    // Index i holds the coefficient feeding parity register r_i.
    localparam logic [SYM_W-1:0] GEN_COEF [4] = '{G0, G1, G2, G3};

    localparam logic [3:0] MSG_LAST_CNT = 4'(K - 1);
    localparam logic [3:0] PAR_LAST_CNT = 4'(N - K - 1);

    typedef enum logic {
        MSG    = 1'b0,
        PARITY = 1'b1
    } state_t;

    // Multiply by alpha: shift up one degree, fold x^4 back as x+1.
    function automatic logic [SYM_W-1:0] gf_xtime(input logic [SYM_W-1:0] a);
        return {a[2:0], 1'b0} ^ (a[3] ? 4'h3 : 4'h0);
    endfunction

endpackage

// File: rtl/rs_encoder_gf16_cmul.sv
// Constant multiplier over GF(16); with C fixed at elaboration this reduces
// to a small XOR network.
module gf16_cmul
    import rs_encoder_pkg::*;
#(
    parameter logic [SYM_W-1:0] C = 4'h1
) (
    input  logic [SYM_W-1:0] a,
    output logic [SYM_W-1:0] y
);

    logic [SYM_W-1:0] pow_a;

    always_comb begin
        y     = '0;
        pow_a = a;
        for (int i = 0; i < SYM_W; i++) begin
            if (C[i]) begin
                y = y ^ pow_a;
            end
            pow_a = gf_xtime(pow_a);
        end
    end

endmodule

// File: rtl/rs_encoder.sv
// Systematic RS(15,11) encoder: passes 11 message symbols through, then emits
// the 4 parity symbols from an LFSR divider, all through one output register.
module rs_encoder
    import rs_encoder_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SYM_W-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [SYM_W-1:0] out_data,
    output logic             out_last
);

    state_t           state_reg;
    logic [3:0]       cnt_reg;
    logic [SYM_W-1:0] r_reg   [4];
    logic [SYM_W-1:0] r_msg   [4];
    logic [SYM_W-1:0] r_shift [4];
    logic [SYM_W-1:0] prod    [4];
    logic [SYM_W-1:0] fb;
    logic             out_valid_reg;
    logic [SYM_W-1:0] out_data_reg;
    logic             out_last_reg;
    logic             load;

    assign load      = !out_valid_reg || out_ready;
    assign in_ready  = load && (state_reg == MSG);
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_last  = out_last_reg;

    assign fb = in_data ^ r_reg[3];

    // r_msg: next parity on a message accept; r_shift: parity drain step.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lfsr
            gf16_cmul #(.C(GEN_COEF[gi])) u_cmul (
                .a (fb),
                .y (prod[gi])
            );
            if (gi == 0) begin : g_low
                assign r_msg[gi]   = prod[gi];
                assign r_shift[gi] = '0;
            end else begin : g_up
                assign r_msg[gi]   = r_reg[gi-1] ^ prod[gi];
                assign r_shift[gi] = r_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= MSG;
            cnt_reg       <= '0;
            for (int i = 0; i < 4; i++) begin
                r_reg[i] <= '0;
            end
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_last_reg  <= 1'b0;
        end else if (load) begin
            case (state_reg)
                MSG: begin
                    out_last_reg <= 1'b0;
                    if (in_valid) begin
                        r_reg         <= r_msg;
                        out_data_reg  <= in_data;
                        out_valid_reg <= 1'b1;
                        if (cnt_reg == MSG_LAST_CNT) begin
                            state_reg <= PARITY;
                            cnt_reg   <= '0;
                        end else begin
                            cnt_reg <= cnt_reg + 4'd1;
                        end
                    end else begin
                        // Bubble: current symbol drains, LFSR untouched.
                        out_valid_reg <= 1'b0;
                    end
                end
                PARITY: begin
                    r_reg         <= r_shift;
                    out_data_reg  <= r_reg[3];
                    out_valid_reg <= 1'b1;
                    out_last_reg  <= (cnt_reg == PAR_LAST_CNT);
                    if (cnt_reg == PAR_LAST_CNT) begin
                        state_reg <= MSG;
                        cnt_reg   <= '0;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                default: begin
                    state_reg <= MSG;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rs_encoder.sv
// Randomized bench for rs_encoder: reference codewords come from polynomial
// long division by g(x); every received codeword is also syndrome-checked.
module tb_rs_encoder;

    typedef logic [3:0] msg_t [11];
    typedef logic [3:0] cw_t  [15];

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b1;
    logic       in_valid  = 1'b0;
    logic [3:0] in_data   = 4'h0;
    logic       out_ready = 1'b1;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_last;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int first_acc = 0;
    int last_cyc = 0;
    int cw_cnt = 0;
    int bubble_cnt = 0;
    bit ready_rand = 1'b0;
    bit contig_en = 1'b0;
    logic [4:0] exp_q [$];
    logic [3:0] rx_cw [15];

    rs_encoder dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] r;
        logic [3:0] x;
        r = 4'h0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) r = r ^ x;
            x = x[3] ? ({x[2:0], 1'b0} ^ 4'h3) : {x[2:0], 1'b0};
        end
        return r;
    endfunction

    // cw[k] is the k-th symbol on the wire (cw[0] = c14).
    task automatic encode(input msg_t m, output cw_t cw);
        logic [3:0] rem [15];
        logic [3:0] g [5];
        logic [3:0] c;
        g[0] = 4'd7; g[1] = 4'd8; g[2] = 4'd12; g[3] = 4'd13; g[4] = 4'd1;
        for (int d = 0; d < 15; d++) rem[d] = 4'h0;
        for (int i = 0; i < 11; i++) rem[14-i] = m[i];
        for (int d = 14; d >= 4; d--) begin
            c = rem[d];
            for (int j = 0; j < 5; j++) rem[d-4+j] = rem[d-4+j] ^ gf_mul(c, g[j]);
        end
        for (int k = 0; k < 15; k++) cw[k] = (k < 11) ? m[k] : rem[14-k];
    endtask

    function automatic logic [3:0] syndrome(input logic [3:0] c [15], input int j);
        logic [3:0] a;
        logic [3:0] s;
        a = 4'h1;
        for (int i = 0; i < j; i++) a = gf_mul(a, 4'h2);
        s = 4'h0;
        for (int k = 0; k < 15; k++) s = gf_mul(s, a) ^ c[k];
        return s;
    endfunction

    task automatic monitor();
        logic [4:0] e;
        int sym_idx;
        int prev_cyc;
        sym_idx = 0;
        prev_cyc = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                sym_idx = 0;
                exp_q.delete();
            end else begin
                if (!out_valid && sym_idx > 0 && sym_idx < 11) bubble_cnt++;
                if (out_valid && out_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_valid", int'(out_valid), 0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("data", int'(out_data), int'(e[3:0]));
                        chk("last", int'(out_last), int'(e[4]));
                        if (contig_en && sym_idx >= 11) chk("parity_contig", cyc - prev_cyc, 1);
                        prev_cyc = cyc;
                        rx_cw[sym_idx] = out_data;
                        if (e[4]) begin
                            last_cyc = cyc;
                            cw_cnt++;
                            for (int j = 1; j <= 4; j++) chk("syndrome", int'(syndrome(rx_cw, j)), 0);
                            $display("codeword %0d received at cycle %0d", cw_cnt, cyc);
                            sym_idx = 0;
                        end else begin
                            sym_idx++;
                        end
                    end
                end
            end
        end
    endtask

    task automatic ready_driver();
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    endtask

    // Sends the first n_syms symbols of m; gap inserts one idle cycle per symbol.
    task automatic send_msg(input msg_t m, input int gap, input int n_syms);
        cw_t cw;
        bit acc;
        encode(m, cw);
        for (int k = 0; k < 15; k++) exp_q.push_back({(k == 14), cw[k]});
        for (int k = 0; k < n_syms; k++) begin
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data = m[k];
            acc = 1'b0;
            for (int t = 0; t < 500 && !acc; t++) begin
                @(negedge clk);
                acc = in_ready;
                if (acc && k == 0) first_acc = cyc + 1;
                @(posedge clk);
                #1;
            end
            chk("accept", int'(acc), 1);
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 2000 && exp_q.size() > 0; t++) @(posedge clk);
        chk("drain", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        msg_t m;
        int cw_before;
        int b0;
        fork
            monitor();
            ready_driver();
        join_none

        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_last", int'(out_last), 0);
        reset_n = 1'b1;
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        @(posedge clk);
        #1;

        // All-zero message: 15 zero symbols, OUT_LAST 14 cycles after first accept.
        contig_en = 1'b1;
        for (int i = 0; i < 11; i++) m[i] = 4'h0;
        send_msg(m, 0, 11);
        drain();
        chk("zero_latency", last_cyc - first_acc, 14);

        m[10] = 4'h1;
        send_msg(m, 0, 11);
        drain();
        chk("unit_p3", int'(rx_cw[11]), 13);
        chk("unit_p2", int'(rx_cw[12]), 12);
        chk("unit_p1", int'(rx_cw[13]), 8);
        chk("unit_p0", int'(rx_cw[14]), 7);

        m[10] = 4'h2;
        send_msg(m, 0, 11);
        drain();
        chk("alpha_p3", int'(rx_cw[11]), 9);
        chk("alpha_p2", int'(rx_cw[12]), 11);
        chk("alpha_p1", int'(rx_cw[13]), 3);
        chk("alpha_p0", int'(rx_cw[14]), 14);

        // Random back-to-back codewords under random backpressure.
        contig_en = 1'b0;
        ready_rand = 1'b1;
        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < 11; i++) m[i] = 4'($urandom_range(0, 15));
            send_msg(m, 0, 11);
        end
        drain();
        ready_rand = 1'b0;
        @(posedge clk);
        #1;

        // Reset after the sixth accept discards the partial codeword.
        for (int i = 0; i < 11; i++) m[i] = 4'($urandom_range(1, 15));
        send_msg(m, 0, 6);
        #1 reset_n = 1'b0;
        #1;
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_out_data", int'(out_data), 0);
        chk("midrst_out_last", int'(out_last), 0);
        @(negedge clk);
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        cw_before = cw_cnt;
        for (int i = 0; i < 11; i++) m[i] = 4'($urandom_range(0, 15));
        send_msg(m, 0, 11);
        drain();
        chk("midrst_fresh_cw", cw_cnt - cw_before, 1);

        // IN_VALID every other cycle: bubbles in the message, contiguous parity.
        contig_en = 1'b1;
        b0 = bubble_cnt;
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 11; i++) m[i] = 4'($urandom_range(0, 15));
            send_msg(m, 1, 11);
        end
        drain();
        chk("toggle_bubbles", int'(bubble_cnt > b0), 1);

        chk("codeword_total", cw_cnt, 28);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
